// File: rtl/truth_table_sequencer_if.sv
// Front-panel bundle of the truth-table sequencer: mode switches and push-button in,
// combination / function / wrap indicators out.
interface truth_table_sequencer_if #(
   parameter int unsigned N_VARS = 2
);
   logic [1:0]        mode;
   logic              step_btn;
   logic [N_VARS-1:0] var_led;
   logic              func_led;
   logic              wrap_pulse;

   modport master (
      output mode,
      output step_btn,
      input  var_led,
      input  func_led,
      input  wrap_pulse
   );

   modport slave (
      input  mode,
      input  step_btn,
      output var_led,
      output func_led,
      output wrap_pulse
   );
endinterface

// File: rtl/truth_table_sequencer.sv
// Walks every input combination of an N_VARS-input Boolean function, showing the
// combination and TRUTH[combination] on LEDs, stepped by a dwell timer or a debounced button.
module truth_table_sequencer #(
   parameter int unsigned                   N_VARS          = 2,
   parameter logic [(1 << N_VARS)-1:0]      TRUTH           = 4'b1011,
   parameter int unsigned                   DWELL_CYCLES    = 100_000_000,
   parameter int unsigned                   DEBOUNCE_CYCLES = 500_000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   truth_table_sequencer_if.slave    bus
);

   localparam int unsigned DW_W = (DWELL_CYCLES    > 1) ? $clog2(DWELL_CYCLES)    : 1;
   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_UP   = 2'b00,
      ST_MAN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_DOWN = 2'b11
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_sync1;
   logic                r_sync2;
   logic                r_db_level;
   logic [DB_W-1:0]     r_db_cnt;
   logic                w_db_mismatch;
   logic                w_db_done;
   logic                w_db_rise;

   logic [N_VARS-1:0]   r_index;
   logic [N_VARS-1:0]   w_index_nxt;
   logic [DW_W-1:0]     r_dwell;
   logic [DW_W-1:0]     w_dwell_nxt;
   logic                w_dwell_term;
   logic                r_wrap;
   logic                w_wrap_nxt;

   logic [N_VARS-1:0]   r_var_led;
   logic                r_func_led;
   logic                r_wrap_pulse;

   // Two-flop synchroniser and level debouncer; a rise is flagged on the accepting cycle
   assign w_db_mismatch = (r_sync2 != r_db_level);
   assign w_db_done     = (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
   assign w_db_rise     = w_db_mismatch & w_db_done & r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_db_level <= 1'b0;
         r_db_cnt   <= '0;
      end else begin
         r_sync1 <= bus.step_btn;
         r_sync2 <= r_sync1;
         if (w_db_mismatch) begin
            if (w_db_done) begin
               r_db_level <= r_sync2;
               r_db_cnt   <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + DB_W'(1);
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   assign w_dwell_term = (r_dwell == DW_W'(DWELL_CYCLES - 1));

   // State register: the registered operating mode, plus index/dwell/wrap datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_UP;
         r_index <= '0;
         r_dwell <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_index <= w_index_nxt;
         r_dwell <= w_dwell_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   // A mode change only restarts the dwell; button rises outside manual mode are dropped
   always_comb begin
      w_state_nxt = state_t'(bus.mode);
      w_index_nxt = r_index;
      w_dwell_nxt = r_dwell;
      w_wrap_nxt  = 1'b0;
      if (w_state_nxt != r_state) begin
         w_dwell_nxt = '0;
      end else begin
         case (r_state)
            ST_UP: begin
               if (w_dwell_term) begin
                  w_dwell_nxt = '0;
                  w_index_nxt = r_index + N_VARS'(1);
                  w_wrap_nxt  = &r_index;
               end else begin
                  w_dwell_nxt = r_dwell + DW_W'(1);
               end
            end
            ST_DOWN: begin
               if (w_dwell_term) begin
                  w_dwell_nxt = '0;
                  w_index_nxt = r_index - N_VARS'(1);
                  w_wrap_nxt  = ~|r_index;
               end else begin
                  w_dwell_nxt = r_dwell + DW_W'(1);
               end
            end
            ST_MAN: begin
               w_dwell_nxt = '0;
               if (w_db_rise) begin
                  w_index_nxt = r_index + N_VARS'(1);
                  w_wrap_nxt  = &r_index;
               end
            end
            default: begin
               w_dwell_nxt = r_dwell;
            end
         endcase
      end
   end

   // Output registers trail the index by one clock; the wrap strobe is kept aligned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_var_led    <= '0;
         r_func_led   <= TRUTH[0];
         r_wrap_pulse <= 1'b0;
      end else begin
         r_var_led    <= r_index;
         r_func_led   <= TRUTH[r_index];
         r_wrap_pulse <= r_wrap;
      end
   end

   assign bus.var_led    = r_var_led;
   assign bus.func_led   = r_func_led;
   assign bus.wrap_pulse = r_wrap_pulse;

endmodule
